// File: rtl/conv_window_buffer.sv
// conv_window_buffer: raster-order pixel stream to a 3x3 sliding window.
// Ports: clk, reset (async high), frame_start, in_valid, in_pixel[7:0]
//        -> pixel_1..pixel_9 (row-major window), win_valid, frame_done.
module conv_window_buffer #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       in_valid,
    input  logic [7:0] in_pixel,
    output logic [7:0] pixel_1,
    output logic [7:0] pixel_2,
    output logic [7:0] pixel_3,
    output logic [7:0] pixel_4,
    output logic [7:0] pixel_5,
    output logic [7:0] pixel_6,
    output logic [7:0] pixel_7,
    output logic [7:0] pixel_8,
    output logic [7:0] pixel_9,
    output logic       win_valid,
    output logic       frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef enum logic {FILL, ACTIVE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_col;
    logic [CW-1:0]   w_col;
    logic [CW-1:0]   w_col_nxt;
    logic [RW-1:0]   r_row;
    logic [RW-1:0]   w_row;
    logic [RW-1:0]   w_row_nxt;
    logic            w_last_col;
    logic            w_last_row;
    logic            w_win;
    logic            w_done;
    logic            r_win_valid;
    logic            r_frame_done;
    logic [7:0]      r_lb0 [IMG_WIDTH];
    logic [7:0]      r_lb1 [IMG_WIDTH];
    logic [7:0]      w_lb0_rd;
    logic [7:0]      w_lb1_rd;
    logic [7:0]      r_win [9];

    // frame_start redefines the current pixel position as (0,0)
    always_comb begin
        w_col       = frame_start ? '0 : r_col;
        w_row       = frame_start ? '0 : r_row;
        w_last_col  = (w_col == CW'(IMG_WIDTH - 1));
        w_last_row  = (w_row == RW'(IMG_HEIGHT - 1));
        w_lb0_rd    = r_lb0[w_col];
        w_lb1_rd    = r_lb1[w_col];
        w_col_nxt   = w_col;
        w_row_nxt   = w_row;
        w_state_nxt = frame_start ? FILL : r_state;
        w_win       = 1'b0;
        w_done      = 1'b0;
        if (in_valid) begin
            w_col_nxt = w_last_col ? '0 : w_col + 1'b1;
            if (w_last_col) begin
                w_row_nxt = w_last_row ? '0 : w_row + 1'b1;
            end
            // ACTIVE implies row>=2, so only col gates the window
            w_win  = (r_state == ACTIVE) && !frame_start &&
                     (w_col >= CW'(2));
            w_done = w_win && w_last_col && w_last_row;
            if (w_last_col && w_row == RW'(1)) begin
                w_state_nxt = ACTIVE;
            end else if (w_last_col && w_last_row) begin
                w_state_nxt = FILL;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= FILL;
            r_col        <= '0;
            r_row        <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_win_valid  <= w_win;
            r_frame_done <= w_done;
            if (in_valid) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= w_lb1_rd;
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= w_lb0_rd;
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= in_pixel;
            end
        end
    end

    // Line buffers are never cleared; FILL masks stale rows
    always_ff @(posedge clk) begin
        if (in_valid && !reset) begin
            r_lb1[w_col] <= w_lb0_rd;
            r_lb0[w_col] <= in_pixel;
        end
    end

    assign pixel_1    = r_win[0];
    assign pixel_2    = r_win[1];
    assign pixel_3    = r_win[2];
    assign pixel_4    = r_win[3];
    assign pixel_5    = r_win[4];
    assign pixel_6    = r_win[5];
    assign pixel_7    = r_win[6];
    assign pixel_8    = r_win[7];
    assign pixel_9    = r_win[8];
    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_window_buffer.sv
// tb_conv_window_buffer: directed bench for conv_window_buffer, 4x4 image.
// Pixel value is 16*row+col, optionally offset or constant per frame.
module tb_conv_window_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       in_valid;
    logic [7:0] in_pixel;
    logic [7:0] pixel_1, pixel_2, pixel_3;
    logic [7:0] pixel_4, pixel_5, pixel_6;
    logic [7:0] pixel_7, pixel_8, pixel_9;
    logic       win_valid;
    logic       frame_done;
    logic [71:0] obs;

    int ncmp  = 0;
    int nfail = 0;

    conv_window_buffer #(
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_pixel    (in_pixel),
        .pixel_1     (pixel_1),
        .pixel_2     (pixel_2),
        .pixel_3     (pixel_3),
        .pixel_4     (pixel_4),
        .pixel_5     (pixel_5),
        .pixel_6     (pixel_6),
        .pixel_7     (pixel_7),
        .pixel_8     (pixel_8),
        .pixel_9     (pixel_9),
        .win_valid   (win_valid),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    assign obs = {pixel_1, pixel_2, pixel_3,
                  pixel_4, pixel_5, pixel_6,
                  pixel_7, pixel_8, pixel_9};

    // mode 0: 16r+c, 1: 16r+c+0x80, 2: zero, 3: 0xFF
    function automatic logic [7:0] pix(input int r, input int c,
                                       input int m);
        case (m)
            0:       return 8'(16 * r + c);
            1:       return 8'(16 * r + c + 128);
            2:       return 8'h00;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [71:0] exp_win(input int r, input int c,
                                            input int m);
        logic [71:0] w;
        w = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                w = {w[63:0], pix(r - 2 + dr, c - 2 + dc, m)};
            end
        end
        return w;
    endfunction

    task automatic feed(input logic v, input logic fs,
                        input logic [7:0] p);
        @(negedge clk);
        in_valid    = v;
        frame_start = fs;
        in_pixel    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        in_pixel    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        ncmp++;
        if (win_valid !== 1'b0) begin
            nfail++;
            $display("FAIL reset_wv got %b exp 0", win_valid);
        end
        ncmp++;
        if (frame_done !== 1'b0) begin
            nfail++;
            $display("FAIL reset_fd got %b exp 0", frame_done);
        end
        ncmp++;
        if (obs !== 72'h0) begin
            nfail++;
            $display("FAIL reset_win got %h exp 0", obs);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_stream();
        int nw;
        int r;
        int c;
        nw = 0;
        for (int i = 0; i < 16; i++) begin
            r = i / 4;
            c = i % 4;
            feed(1'b1, 1'b0, pix(r, c, 0));
            if (win_valid === 1'b1) nw++;
            ncmp++;
            if (win_valid !== (r >= 2 && c >= 2)) begin
                nfail++;
                $display("FAIL stream_wv r%0d c%0d got %b", r, c,
                         win_valid);
            end
            ncmp++;
            if (frame_done !== (r == 3 && c == 3)) begin
                nfail++;
                $display("FAIL stream_fd r%0d c%0d got %b", r, c,
                         frame_done);
            end
            if (r >= 2 && c >= 2) begin
                ncmp++;
                if (obs !== exp_win(r, c, 0)) begin
                    nfail++;
                    $display("FAIL stream_win r%0d c%0d got %h exp %h",
                             r, c, obs, exp_win(r, c, 0));
                end
            end
        end
        ncmp++;
        if (nw != 4) begin
            nfail++;
            $display("FAIL stream_count got %0d exp 4", nw);
        end
    endtask

    task automatic test_gaps();
        int nw;
        int r;
        int c;
        nw = 0;
        for (int i = 0; i < 16; i++) begin
            r = i / 4;
            c = i % 4;
            feed(1'b1, 1'b0, pix(r, c, 0));
            if (win_valid === 1'b1) nw++;
            ncmp++;
            if (win_valid !== (r >= 2 && c >= 2)) begin
                nfail++;
                $display("FAIL gap_wv r%0d c%0d got %b", r, c,
                         win_valid);
            end
            ncmp++;
            if (frame_done !== (r == 3 && c == 3)) begin
                nfail++;
                $display("FAIL gap_fd r%0d c%0d got %b", r, c,
                         frame_done);
            end
            feed(1'b0, 1'b0, 8'hEE);
            ncmp++;
            if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
                nfail++;
                $display("FAIL gap_idle r%0d c%0d got wv%b fd%b",
                         r, c, win_valid, frame_done);
            end
            if (r >= 2 && c >= 2) begin
                ncmp++;
                if (obs !== exp_win(r, c, 0)) begin
                    nfail++;
                    $display("FAIL gap_hold r%0d c%0d got %h exp %h",
                             r, c, obs, exp_win(r, c, 0));
                end
            end
        end
        ncmp++;
        if (nw != 4) begin
            nfail++;
            $display("FAIL gap_count got %0d exp 4", nw);
        end
    endtask

    task automatic test_back_to_back();
        int nw;
        int r;
        int c;
        int m;
        nw = 0;
        for (int i = 0; i < 32; i++) begin
            m = i / 16;
            r = (i % 16) / 4;
            c = i % 4;
            feed(1'b1, 1'b0, pix(r, c, m));
            if (win_valid === 1'b1 && m == 1) nw++;
            ncmp++;
            if (win_valid !== (r >= 2 && c >= 2)) begin
                nfail++;
                $display("FAIL b2b_wv f%0d r%0d c%0d got %b", m, r, c,
                         win_valid);
            end
            ncmp++;
            if (frame_done !== (r == 3 && c == 3)) begin
                nfail++;
                $display("FAIL b2b_fd f%0d r%0d c%0d got %b", m, r, c,
                         frame_done);
            end
            if (r >= 2 && c >= 2) begin
                ncmp++;
                if (obs !== exp_win(r, c, m)) begin
                    nfail++;
                    $display("FAIL b2b_win f%0d r%0d c%0d got %h exp %h",
                             m, r, c, obs, exp_win(r, c, m));
                end
            end
        end
        ncmp++;
        if (nw != 4) begin
            nfail++;
            $display("FAIL b2b_count got %0d exp 4", nw);
        end
    endtask

    task automatic test_mid_reset();
        int nw;
        int r;
        int c;
        for (int i = 0; i < 10; i++) begin
            feed(1'b1, 1'b0, pix(i / 4, i % 4, 0));
        end
        #2;
        reset = 1'b1;
        #1;
        ncmp++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
            nfail++;
            $display("FAIL mrst_flags got wv%b fd%b exp 0", win_valid,
                     frame_done);
        end
        ncmp++;
        if (obs !== 72'h0) begin
            nfail++;
            $display("FAIL mrst_win got %h exp 0", obs);
        end
        feed(1'b1, 1'b1, 8'h55);
        feed(1'b1, 1'b0, 8'h66);
        ncmp++;
        if (obs !== 72'h0 || win_valid !== 1'b0) begin
            nfail++;
            $display("FAIL mrst_ignore got %h wv%b exp 0", obs,
                     win_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        frame_start = 1'b0;
        reset = 1'b0;
        nw = 0;
        for (int i = 0; i < 16; i++) begin
            r = i / 4;
            c = i % 4;
            feed(1'b1, 1'b0, pix(r, c, 0));
            if (win_valid === 1'b1) nw++;
            ncmp++;
            if (win_valid !== (r >= 2 && c >= 2)) begin
                nfail++;
                $display("FAIL mrst_wv r%0d c%0d got %b", r, c,
                         win_valid);
            end
            if (r >= 2 && c >= 2) begin
                ncmp++;
                if (obs !== exp_win(r, c, 0)) begin
                    nfail++;
                    $display("FAIL mrst_win2 r%0d c%0d got %h exp %h",
                             r, c, obs, exp_win(r, c, 0));
                end
            end
        end
        ncmp++;
        if (nw != 4) begin
            nfail++;
            $display("FAIL mrst_count got %0d exp 4", nw);
        end
    endtask

    task automatic test_frame_start();
        int nw;
        int nd;
        int r;
        int c;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            feed(1'b1, 1'b0, pix(i / 4, i % 4, 0));
            if (frame_done === 1'b1) nd++;
        end
        nw = 0;
        for (int i = 0; i < 16; i++) begin
            r = i / 4;
            c = i % 4;
            feed(1'b1, (i == 0), pix(r, c, 1));
            if (win_valid === 1'b1) nw++;
            if (frame_done === 1'b1 && i != 15) nd++;
            ncmp++;
            if (win_valid !== (r >= 2 && c >= 2)) begin
                nfail++;
                $display("FAIL fs_wv r%0d c%0d got %b", r, c,
                         win_valid);
            end
            if (r >= 2 && c >= 2) begin
                ncmp++;
                if (obs !== exp_win(r, c, 1)) begin
                    nfail++;
                    $display("FAIL fs_win r%0d c%0d got %h exp %h",
                             r, c, obs, exp_win(r, c, 1));
                end
            end
        end
        ncmp++;
        if (frame_done !== 1'b1) begin
            nfail++;
            $display("FAIL fs_last_fd got %b exp 1", frame_done);
        end
        ncmp++;
        if (nd != 0) begin
            nfail++;
            $display("FAIL fs_trunc_fd got %0d exp 0", nd);
        end
        ncmp++;
        if (nw != 4) begin
            nfail++;
            $display("FAIL fs_count got %0d exp 4", nw);
        end
        for (int i = 0; i < 7; i++) begin
            feed(1'b1, 1'b0, 8'h44);
        end
        feed(1'b0, 1'b1, 8'h00);
        nw = 0;
        for (int i = 0; i < 16; i++) begin
            r = i / 4;
            c = i % 4;
            feed(1'b1, 1'b0, pix(r, c, 0));
            if (win_valid === 1'b1) nw++;
            if (r >= 2 && c >= 2) begin
                ncmp++;
                if (obs !== exp_win(r, c, 0)) begin
                    nfail++;
                    $display("FAIL fsi_win r%0d c%0d got %h exp %h",
                             r, c, obs, exp_win(r, c, 0));
                end
            end
        end
        ncmp++;
        if (nw != 4 || frame_done !== 1'b1) begin
            nfail++;
            $display("FAIL fsi_count got %0d fd%b exp 4 fd1", nw,
                     frame_done);
        end
    endtask

    task automatic test_const();
        int nw;
        int r;
        int c;
        for (int i = 0; i < 16; i++) begin
            feed(1'b1, 1'b0, 8'h00);
        end
        nw = 0;
        for (int i = 0; i < 16; i++) begin
            r = i / 4;
            c = i % 4;
            feed(1'b1, 1'b0, 8'hFF);
            if (win_valid === 1'b1) begin
                nw++;
                ncmp++;
                if (obs !== {9{8'hFF}}) begin
                    nfail++;
                    $display("FAIL const_win r%0d c%0d got %h exp ff",
                             r, c, obs);
                end
            end
        end
        ncmp++;
        if (nw != 4) begin
            nfail++;
            $display("FAIL const_count got %0d exp 4", nw);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
        test_frame_start();
        test_const();
        feed(1'b0, 1'b0, 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/conv_window_buffer.md
CONV_WINDOW_BUFFER -- requirements
Module: conv_window_buffer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 64, meaning pixels per row (legal range 3..1024).
REQ-002 SHALL have parameter IMG_HEIGHT, default 64, meaning rows per frame (legal range 3..1024).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port frame_start  input  1  forces the current in_valid pixel, or the next one, to be pixel (row 0, col 0).
REQ-006 SHALL have port in_valid  input  1  in_pixel is valid this cycle.
REQ-007 SHALL have port in_pixel  input  8  unsigned raster-order pixel.
REQ-008 SHALL have ports pixel_1..pixel_9  output  8 each  3x3 window in row-major order: pixel_1 is top-left, pixel_9 is bottom-right; these drive the convolution stage pixel inputs.
REQ-009 SHALL have port win_valid  output  1  pixel_1..pixel_9 hold a complete window this cycle.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-011 SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) that advance only on in_valid; col wraps to 0 with row+1; on (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0.
REQ-012 SHALL hold two line buffers, LB0 for row-1 and LB1 for row-2, each IMG_WIDTH x 8 bits, indexed by col.
REQ-013 SHALL, on in_valid, shift the 3x3 window register left one column and load the right column with {LB1[col], LB0[col], in_pixel} as (top, middle, bottom).
REQ-014 SHALL, on the same in_valid edge, write LB1[col] <= LB0[col] and LB0[col] <= in_pixel, using pre-edge read values.
REQ-015 SHALL assert win_valid in the cycle after an accepted pixel with row>=2 and col>=2, and deassert it otherwise; latency from pixel (r,c) to its window is exactly 1 cycle.
REQ-016 SHALL hold pixel_1..pixel_9 and keep win_valid low on cycles following in_valid=0; gaps in the input stream do not corrupt the window.
REQ-017 SHALL produce exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) win_valid cycles per frame (valid-only convolution, no padding); a window never spans two rows.
REQ-018 SHALL operate in two states: FILL while row<2, with windows suppressed; ACTIVE while row>=2. ACTIVE returns to FILL on frame wrap or on frame_start.
REQ-019 SHALL, when frame_start=1 with in_valid=1, treat in_pixel as (0,0), then set col=1, row=0 and enter FILL; frame_done is not pulsed for the truncated frame.
REQ-020 SHALL, when frame_start=1 with in_valid=0, set col=0, row=0 and enter FILL; the next accepted pixel is (0,0).
REQ-021 SHALL pulse frame_done high for one cycle, in the same cycle as the window for pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-022 SHALL not require line buffer contents to be cleared between frames; stale data is masked by FILL.

Reset
REQ-023 SHALL, on reset=1 and independent of clk, force col=0, row=0, state FILL, win_valid=0, frame_done=0 and pixel_1..pixel_9=0.
REQ-024 SHALL leave line buffer contents undefined after reset; the first full window after reset SHALL contain only post-reset pixels.
REQ-025 SHALL ignore in_valid and frame_start while reset=1; after a mid-frame reset, the first pixel accepted is (0,0).

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = 16*row+col)
REQ-026 SHALL cover: continuous stream of frame 1 -> first win_valid one cycle after pixel 0x22, with pixel_1..9 = 00,01,02,10,11,12,20,21,22; 4 windows total; last window ends with pixel_9=0x33 and frame_done=1 in the same cycle.
REQ-027 SHALL cover: in_valid toggled 1/0 every cycle over a full frame -> same 4 windows with identical contents, each win_valid one cycle wide, outputs held in gaps.
REQ-028 SHALL cover: two back-to-back frames with frame 2 values +0x80 -> frame 2 windows contain only frame-2 values (first window pixel_1=0x80, pixel_9=0xA2), with no win_valid during rows 0-1 of frame 2.
REQ-029 SHALL cover: reset asserted asynchronously after pixel 0x21 -> win_valid, frame_done and pixel_* go 0 immediately; restarted frame yields first window 00..22 as in REQ-026.
REQ-030 SHALL cover: frame_start with in_valid at pixel 0x12 of frame 1, followed by a fresh frame -> no frame_done for the truncated frame; 4 windows from the new frame with correct contents.
REQ-031 SHALL cover: all-zero frame, then a frame of constant 0xFF -> all windows of the second frame have pixel_1..9 = 0xFF, and win_valid count = 4.
